// File: rtl/mult_mode_manager_multi.sv
// mult_mode_manager_multi
//
// Multi-channel multiplier mode manager. Each channel XOR-inverts its
// MULTMODE field and then presents either a registered copy or the live
// (bypass) value. All per-channel configuration lives in one serial chain.
// Whenever a channel's effective mode changes, mode_change pulses for one
// cycle and mode_valid drops for SETTLE cycles so the downstream fracturable
// multiplier can drain its pipeline.
//
// Ports
//   clk           : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   multmode_in   : raw mode fields, channel c at [c*MODE_W +: MODE_W]
//   rst_multmode  : per-channel synchronous mode-register reset (polarity via RSTINV)
//   ce_multmode   : per-channel mode-register clock enable
//   multmode      : effective mode fields, same packing as multmode_in
//   mode_valid    : channel mode stable and configuration complete
//   mode_change   : one-cycle registered pulse per detected mode change
//   cfg_in        : serial configuration data
//   cfg_en        : configuration shift enable
//   cfg_out       : configuration chain tail (daisy-chain output)
//   cfg_ready     : full chain has been shifted in at least once
//
// Chain layout (bit position p of the chain, position 0 nearest cfg_in):
//   channel c occupies positions c*(MODE_W+2) ...:
//     +0            MODEREG[c]
//     +1..+MODE_W   INV[c][0..MODE_W-1]
//     +MODE_W+1     RSTINV[c]
//   cfg_out is the last position, i.e. RSTINV[NUM_CH-1].

module mult_mode_manager_multi #(
    parameter int NUM_CH = 2,
    parameter int MODE_W = 4,
    parameter int SETTLE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH*MODE_W-1:0]   multmode_in,
    input  logic [NUM_CH-1:0]          rst_multmode,
    input  logic [NUM_CH-1:0]          ce_multmode,
    output logic [NUM_CH*MODE_W-1:0]   multmode,
    output logic [NUM_CH-1:0]          mode_valid,
    output logic [NUM_CH-1:0]          mode_change,
    input  logic                       cfg_in,
    input  logic                       cfg_en,
    output logic                       cfg_out,
    output logic                       cfg_ready
);

    localparam int SEG     = MODE_W + 2;
    localparam int CFG_LEN = NUM_CH * SEG;
    localparam int CFG_CW  = $clog2(CFG_LEN + 1);
    // SETTLE may be 0; keep the counter at least one bit wide.
    localparam int CNT_W   = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    logic [CFG_LEN-1:0] chain;
    logic [CFG_CW-1:0]  cfg_cnt;

    // Configuration chain and saturating shift counter. Once the counter
    // saturates it stays there until rst_n, even if shifting continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '0;
            cfg_cnt <= '0;
        end else if (cfg_en) begin
            chain <= {chain[CFG_LEN-2:0], cfg_in};
            if (cfg_cnt != CFG_CW'(CFG_LEN)) begin
                cfg_cnt <= cfg_cnt + CFG_CW'(1);
            end
        end
    end

    assign cfg_out   = chain[CFG_LEN-1];
    assign cfg_ready = (cfg_cnt == CFG_CW'(CFG_LEN));

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic              cfg_modereg;
        logic [MODE_W-1:0] cfg_inv;
        logic              cfg_rstinv;
        logic [MODE_W-1:0] xin;
        logic              xrst;
        logic [MODE_W-1:0] mreg;
        logic [MODE_W-1:0] field;
        logic [MODE_W-1:0] prev;
        logic [CNT_W-1:0]  cnt;
        logic              chg;

        assign cfg_modereg = chain[c*SEG];
        assign cfg_inv     = chain[c*SEG+1 +: MODE_W];
        assign cfg_rstinv  = chain[c*SEG+MODE_W+1];

        assign xin  = multmode_in[c*MODE_W +: MODE_W] ^ cfg_inv;
        assign xrst = rst_multmode[c] ^ cfg_rstinv;

        // Mode register: synchronous reset has priority over enable.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mreg <= '0;
            end else if (xrst) begin
                mreg <= '0;
            end else if (ce_multmode[c]) begin
                mreg <= xin;
            end
        end

        assign field = cfg_modereg ? mreg : xin;
        assign multmode[c*MODE_W +: MODE_W] = field;

        // Change detector and settle counter. A change while the count is
        // running reloads it, so the quiet window is extended rather than
        // queued behind the current one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prev <= '0;
                cnt  <= '0;
                chg  <= 1'b0;
            end else begin
                prev <= field;
                if (field != prev) begin
                    cnt <= CNT_W'(SETTLE);
                    chg <= 1'b1;
                end else begin
                    chg <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            end
        end

        assign mode_change[c] = chg;
        assign mode_valid[c]  = cfg_ready & ~cfg_en & (cnt == '0);
    end

endmodule

// File: tb/tb_mult_mode_manager_multi.sv
// Testbench for mult_mode_manager_multi (NUM_CH=2, MODE_W=4, SETTLE=3).
// A behavioural reference model tracks the configuration as the list of bits
// shifted in, the mode registers, the last observed output of each channel
// and the cycle number of each channel's most recent mode change; all
// expected outputs are derived from those.

module tb_mult_mode_manager_multi;

    localparam int NUM_CH  = 2;
    localparam int MODE_W  = 4;
    localparam int SETTLE  = 3;
    localparam int SEG     = MODE_W + 2;
    localparam int CFG_LEN = NUM_CH * SEG;
    localparam int W       = NUM_CH * MODE_W;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0]      multmode_in = '0;
    logic [NUM_CH-1:0] rst_multmode = '0;
    logic [NUM_CH-1:0] ce_multmode = '0;
    logic              cfg_in = 1'b0;
    logic              cfg_en = 1'b0;
    logic [W-1:0]      multmode;
    logic [NUM_CH-1:0] mode_valid;
    logic [NUM_CH-1:0] mode_change;
    logic              cfg_out;
    logic              cfg_ready;

    always #5 clk = ~clk;

    mult_mode_manager_multi #(
        .NUM_CH (NUM_CH),
        .MODE_W (MODE_W),
        .SETTLE (SETTLE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .multmode_in  (multmode_in),
        .rst_multmode (rst_multmode),
        .ce_multmode  (ce_multmode),
        .multmode     (multmode),
        .mode_valid   (mode_valid),
        .mode_change  (mode_change),
        .cfg_in       (cfg_in),
        .cfg_en       (cfg_en),
        .cfg_out      (cfg_out),
        .cfg_ready    (cfg_ready)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    bit                hist[$];      // configuration bits, oldest first
    int                nshift;
    logic [MODE_W-1:0] mreg_m[NUM_CH];
    logic [MODE_W-1:0] prev_m[NUM_CH];
    int                last_chg[NUM_CH];
    int                cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Chain position p holds the bit shifted in p edges before the newest one.
    function automatic bit cfg_bit(input int p);
        if (p < hist.size()) return hist[hist.size()-1-p];
        return 1'b0;
    endfunction

    function automatic logic [MODE_W-1:0] inv_of(input int c);
        logic [MODE_W-1:0] v;
        for (int i = 0; i < MODE_W; i++) v[i] = cfg_bit(c*SEG + 1 + i);
        return v;
    endfunction

    function automatic logic [MODE_W-1:0] exp_field(input int c);
        logic [MODE_W-1:0] x;
        x = multmode_in[c*MODE_W +: MODE_W] ^ inv_of(c);
        return cfg_bit(c*SEG) ? mreg_m[c] : x;
    endfunction

    task automatic model_reset();
        hist.delete();
        nshift = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            mreg_m[c]   = '0;
            prev_m[c]   = '0;
            last_chg[c] = -1000;
        end
    endtask

    task automatic check_model();
        logic [W-1:0]      em;
        logic [NUM_CH-1:0] ev;
        logic [NUM_CH-1:0] ec;
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            em[c*MODE_W +: MODE_W] = exp_field(c);
            ev[c] = (nshift == CFG_LEN) && !cfg_en && ((cyc - last_chg[c]) > SETTLE);
            ec[c] = (last_chg[c] == cyc - 1);
        end
        chk("multmode",    32'(multmode),    32'(em));
        chk("mode_valid",  32'(mode_valid),  32'(ev));
        chk("mode_change", 32'(mode_change), 32'(ec));
        chk("cfg_ready",   32'(cfg_ready),   32'(nshift == CFG_LEN));
        chk("cfg_out",     32'(cfg_out),     32'(cfg_bit(CFG_LEN-1)));
    endtask

    task automatic advance();
        logic [MODE_W-1:0] f;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                f = exp_field(c);
                if (f != prev_m[c]) last_chg[c] = cyc;
                prev_m[c] = f;
                if (rst_multmode[c] ^ cfg_bit(c*SEG + MODE_W + 1)) mreg_m[c] = '0;
                else if (ce_multmode[c]) mreg_m[c] = multmode_in[c*MODE_W +: MODE_W] ^ inv_of(c);
            end
            if (cfg_en) begin
                hist.push_back(cfg_in);
                if (hist.size() > CFG_LEN) void'(hist.pop_front());
                if (nshift < CFG_LEN) nshift++;
            end
        end
        cyc++;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        check_model();
        advance();
    endtask

    task automatic reset_dut();
        rst_n  = 1'b0;
        cfg_en = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Word bit p lands in chain position p (MSB shifted first).
    task automatic shift_word(input logic [CFG_LEN-1:0] w);
        for (int i = CFG_LEN - 1; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_in = w[i];
            step();
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [CFG_LEN-1:0] word;
        logic [W-1:0]       din;
        logic [NUM_CH-1:0]  rst;
        logic [NUM_CH-1:0]  ce;
        logic [W-1:0]       exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CFG_LEN-1:0] pat;
        logic [5:0]         mc6;
        logic [5:0]         v6;
        logic [7:0]         mc8;
        logic [7:0]         v8;

        // ch0 reg INV=0011 / ch1 bypass
        tbl[0] = '{12'h007, 8'h35, 2'b00, 2'b01, 8'h36};
        tbl[1] = '{12'h007, 8'h35, 2'b01, 2'b01, 8'h30};
        // ch0 RSTINV=1: rst low resets, rst high loads
        tbl[2] = '{12'h027, 8'h35, 2'b00, 2'b01, 8'h30};
        tbl[3] = '{12'h027, 8'h35, 2'b01, 2'b01, 8'h36};
        // ch1 registered, INV=1111
        tbl[4] = '{12'h7C0, 8'hA5, 2'b00, 2'b10, 8'h55};
        // both registered, ch0 INV=1010, ch1 RSTINV=1
        tbl[5] = '{12'h855, 8'h3C, 2'b00, 2'b11, 8'h06};
        tbl[6] = '{12'h855, 8'h3C, 2'b10, 2'b11, 8'h36};
        // both bypass, full inversion
        tbl[7] = '{12'h79E, 8'hA5, 2'b00, 2'b00, 8'h5A};

        // ---- reset and bypass ----
        model_reset();
        rst_n       = 1'b0;
        multmode_in = 8'hA5;
        #2;
        chk("rst_multmode",    32'(multmode),    32'h0000_00A5);
        chk("rst_mode_valid",  32'(mode_valid),  32'h0);
        chk("rst_mode_change", 32'(mode_change), 32'h0);
        chk("rst_cfg_out",     32'(cfg_out),     32'h0);
        chk("rst_cfg_ready",   32'(cfg_ready),   32'h0);
        step();
        step();
        rst_n = 1'b1;

        pat = 12'b1011_0011_1011;
        for (int i = 0; i < CFG_LEN; i++) begin
            cfg_en = 1'b1;
            cfg_in = pat[i];
            step();
            chk("cfg_ready_rise", 32'(cfg_ready), 32'(i == CFG_LEN - 1));
            chk("cfg_out_tail", 32'(cfg_out), (i == CFG_LEN - 1) ? 32'(pat[0]) : 32'h0);
        end
        cfg_en = 1'b0;
        repeat (5) step();

        // ---- table-driven configuration / register vectors ----
        for (int k = 0; k < 8; k++) begin
            reset_dut();
            rst_multmode = '0;
            ce_multmode  = '0;
            multmode_in  = tbl[k].din;
            shift_word(tbl[k].word);
            rst_multmode = tbl[k].rst;
            ce_multmode  = tbl[k].ce;
            exp_q.push_back(tbl[k].exp);
            step();
            rst_multmode = '0;
            ce_multmode  = '0;
            chk("table_multmode", 32'(multmode), 32'(exp_q.pop_front()));
            chk("table_cfg_ready", 32'(cfg_ready), 32'h1);
        end

        // ---- settle window: ch1 bypass 2 -> 9 ----
        reset_dut();
        multmode_in = 8'h20;
        shift_word('0);
        repeat (6) step();
        multmode_in = 8'h90;
        mc6 = 6'b000010;
        v6  = 6'b110001;
        for (int k = 0; k < 6; k++) begin
            check_model();
            chk("settle_mc1", 32'(mode_change[1]), 32'(mc6[k]));
            chk("settle_v1",  32'(mode_valid[1]),  32'(v6[k]));
            chk("settle_v0",  32'(mode_valid[0]),  32'h1);
            advance();
        end

        // ---- change during count extends the window ----
        multmode_in = 8'h20;
        repeat (6) step();
        multmode_in = 8'h90;
        mc8 = 8'b00001010;
        v8  = 8'b11000001;
        for (int k = 0; k < 8; k++) begin
            check_model();
            chk("extend_mc1", 32'(mode_change[1]), 32'(mc8[k]));
            chk("extend_v1",  32'(mode_valid[1]),  32'(v8[k]));
            advance();
            if (k == 1) multmode_in = 8'h40;
        end

        // ---- async reset mid-count ----
        multmode_in = 8'h20;
        repeat (6) step();
        multmode_in = 8'h90;
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_mode_valid",  32'(mode_valid),  32'h0);
        chk("arst_mode_change", 32'(mode_change), 32'h0);
        chk("arst_cfg_ready",   32'(cfg_ready),   32'h0);
        chk("arst_multmode",    32'(multmode),    32'h0000_0090);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // ---- randomized run against the model ----
        reset_dut();
        shift_word(CFG_LEN'($urandom));
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) multmode_in = W'($urandom);
            rst_multmode = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom_range(0, 3)) : '0;
            ce_multmode  = NUM_CH'($urandom_range(0, 3));
            cfg_en       = ($urandom_range(0, 7) == 0);
            cfg_in       = 1'($urandom_range(0, 1));
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            step();
        end
        rst_n  = 1'b1;
        cfg_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
